// File: rtl/stream_mux_n_1.sv
// stream_mux_n_1: N-channel valid/ready stream mux with fixed-select or round-robin grant and one registered output stage
module stream_mux_n_1 #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_ch
);
  localparam logic [SEL_W:0] N_W = (SEL_W+1)'(N_CH);
  logic [SEL_W-1:0] last_grant, grant, idx;
  logic [SEL_W:0] sum;
  logic grant_valid, load_en;
  assign load_en = !out_valid || out_ready;
  always_comb begin
    grant = '0;
    grant_valid = 1'b0;
    sum = '0;
    idx = '0;
    if (mode) begin
      for (int k = N_CH; k >= 1; k--) begin
        sum = {1'b0, last_grant} + (SEL_W+1)'(k);
        idx = SEL_W'(sum >= N_W ? sum - N_W : sum);
        if (in_valid[idx]) begin
          grant = idx;
          grant_valid = 1'b1;
        end
      end
    end else begin
      grant = sel;
      grant_valid = ({1'b0, sel} < N_W) && in_valid[sel];
    end
  end
  assign in_ready = (load_en && grant_valid && !rst) ? N_CH'(1) << grant : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_W'(N_CH - 1);
    end else if (load_en) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data   <= in_data[grant*WIDTH +: WIDTH];
        out_ch     <= grant;
        last_grant <= grant;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_n_1.sv
// tb_stream_mux_n_1: directed plus random stimulus against a cycle model of the stream mux
module tb_stream_mux_n_1;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b1;
  logic [S-1:0] sel = '0;
  logic [N*W-1:0] in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [N-1:0] in_valid = 4'b1111;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [S-1:0] out_ch;
  int n_chk = 0;
  int n_fail = 0;
  logic m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int m_ch = 0;
  int m_lg = N - 1;
  stream_mux_n_1 #(.N_CH(N), .WIDTH(W), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    int g;
    int c;
    logic [N-1:0] er;
    g = -1;
    if (!rst && (!m_valid || out_ready)) begin
      if (!mode) begin
        if (sel < N && in_valid[sel]) g = sel;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_lg + k) % N;
          if (g < 0 && in_valid[c]) g = c;
        end
      end
    end
    er = (g < 0) ? '0 : N'(1) << g;
    chk("m_in_ready", 32'(in_ready), 32'(er));
    chk("m_out_valid", 32'(out_valid), 32'(m_valid));
    chk("m_out_data", 32'(out_data), 32'(m_data));
    chk("m_out_ch", 32'(out_ch), 32'(m_ch));
    if (rst) begin
      m_valid = 1'b0;
      m_data = '0;
      m_ch = 0;
      m_lg = N - 1;
    end else if (!m_valid || out_ready) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = in_data[g*W +: W];
        m_ch = g;
        m_lg = g;
      end
    end
  end
  initial begin
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_ready2", 32'(in_ready), 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_ch", 32'(out_ch), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'hA0 + 32'(i % 4));
    end
    nxt();
    in_valid = 4'b0011;
    @(negedge clk);
    chk("wrap_ch2", 32'(out_ch), 2);
    chk("wrap_ready0", 32'(in_ready), 32'h1);
    @(negedge clk);
    chk("wrap_ch0", 32'(out_ch), 0);
    chk("wrap_ready1", 32'(in_ready), 32'h2);
    @(negedge clk);
    chk("wrap_ch1", 32'(out_ch), 1);
    chk("wrap_data1", 32'(out_data), 32'hA1);
    nxt();
    mode = 1'b0;
    sel = 2'd2;
    in_valid = 4'b0100;
    in_data[2*W +: W] = 8'h11;
    @(negedge clk);
    chk("fix_ready", 32'(in_ready), 32'h4);
    nxt();
    in_data[2*W +: W] = 8'h22;
    @(negedge clk);
    chk("fix_d11", 32'(out_data), 32'h11);
    chk("fix_ch", 32'(out_ch), 2);
    nxt();
    in_data[2*W +: W] = 8'h33;
    @(negedge clk);
    chk("fix_d22", 32'(out_data), 32'h22);
    nxt();
    in_valid = 4'b0000;
    @(negedge clk);
    chk("fix_d33", 32'(out_data), 32'h33);
    chk("fix_v33", 32'(out_valid), 1);
    @(negedge clk);
    chk("fix_drain_v", 32'(out_valid), 0);
    chk("fix_hold_d", 32'(out_data), 32'h33);
    nxt();
    mode = 1'b1;
    in_valid = 4'b0010;
    in_data[1*W +: W] = 8'h5C;
    @(negedge clk);
    chk("bp_ready", 32'(in_ready), 32'h2);
    nxt();
    out_ready = 1'b0;
    in_valid = 4'b1000;
    in_data[3*W +: W] = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_data", 32'(out_data), 32'h5C);
      chk("bp_ch", 32'(out_ch), 1);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ready0", 32'(in_ready), 0);
    end
    nxt();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ready", 32'(in_ready), 32'h8);
    nxt();
    mode = 1'b0;
    sel = 2'd3;
    in_valid = 4'b0111;
    @(negedge clk);
    chk("nb_data", 32'(out_data), 32'h77);
    chk("nb_ch", 32'(out_ch), 3);
    chk("nb_valid", 32'(out_valid), 1);
    chk("sel3_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("sel3_valid", 32'(out_valid), 0);
    chk("sel3_hold", 32'(out_data), 32'h77);
    nxt();
    mode = 1'b1;
    in_valid = 4'b1000;
    @(negedge clk);
    chk("mid_ready", 32'(in_ready), 32'h8);
    nxt();
    rst = 1'b1;
    in_valid = 4'b1111;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(negedge clk);
    chk("mid_valid", 32'(out_valid), 1);
    chk("mid_rst_ready", 32'(in_ready), 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready0", 32'(in_ready), 32'h1);
    @(negedge clk);
    chk("mid_rst_ch", 32'(out_ch), 0);
    chk("mid_rst_data", 32'(out_data), 32'hA0);
    for (int i = 0; i < 400; i++) begin
      nxt();
      rst = ($urandom_range(0, 59) == 0);
      mode = 1'($urandom);
      sel = S'($urandom);
      in_valid = N'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    nxt();
    rst = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
